// File: rtl/core_run_monitor.sv
// core_run_monitor: run-control and halt/timeout monitor for the pipelined core.
// The monitor samples fetch and execute stage signals every clock while it runs.
// It counts active cycles and retired (non-NOP) instructions.
// The run ends, with sticky status, on either of these:
//   - HALT: a stuck fetch PC, or the self-loop halt instruction reaching EX.
//   - TIMEOUT: MAX_CYCLES active cycles have elapsed.
module core_run_monitor #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    CNT_WIDTH   = 16,
  parameter int                    MAX_CYCLES  = 100,
  parameter int                    HALT_REPEAT = 4,
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR  = 32'h1000FFFF,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR   = 32'h00000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run_en,
  input  logic [DATA_WIDTH-1:0] pc_IF,
  input  logic [DATA_WIDTH-1:0] instr_ID,
  input  logic [DATA_WIDTH-1:0] instr_EX,
  output logic [1:0]            state,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [CNT_WIDTH-1:0]  instr_count,
  output logic                  done,
  output logic                  halted,
  output logic                  timeout,
  output logic [DATA_WIDTH-1:0] last_pc
);

  // Repeat counter must be able to hold HALT_REPEAT itself (it saturates there)
  localparam int REP_W = (HALT_REPEAT < 1) ? 1 : $clog2(HALT_REPEAT + 1);

  localparam logic [REP_W-1:0]     REP_LIMIT = REP_W'(HALT_REPEAT);
  localparam logic [CNT_WIDTH-1:0] TO_LAST   = CNT_WIDTH'(MAX_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [REP_W-1:0]     REP_ONE   = REP_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_HALT    = 2'b10,
    ST_TIMEOUT = 2'b11
  } state_t;

  state_t                 state_q;
  logic [DATA_WIDTH-1:0]  pc_prev;
  logic                   pc_prev_valid;
  logic [REP_W-1:0]       rep_cnt;

  logic [REP_W-1:0]       rep_next;
  logic [CNT_WIDTH-1:0]   cycle_next;
  logic [CNT_WIDTH-1:0]   instr_next;
  logic                   halt_hit;
  logic                   to_hit;

  // The decode-stage instruction is exported for trace only; fold it away here
  logic unused_trace;
  assign unused_trace = ^instr_ID;

  // Next-value and terminating-condition logic for one active RUN cycle
  always_comb begin
    rep_next   = '0;
    cycle_next = cycle_count;
    instr_next = instr_count;

    if (cycle_count != '1) begin
      cycle_next = cycle_count + CNT_ONE;
    end

    if ((instr_EX != NOP_INSTR) && (instr_count != '1)) begin
      instr_next = instr_count + CNT_ONE;
    end

    if (pc_prev_valid && (pc_IF == pc_prev)) begin
      rep_next = (rep_cnt == REP_LIMIT) ? rep_cnt : rep_cnt + REP_ONE;
    end

    halt_hit = (instr_EX == HALT_INSTR) || (rep_next == REP_LIMIT);
    to_hit   = (cycle_count == TO_LAST);
  end

  // Run-control FSM together with its counters, repeat tracking and captured PC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cycle_count   <= '0;
      instr_count   <= '0;
      rep_cnt       <= '0;
      pc_prev       <= '0;
      pc_prev_valid <= 1'b0;
      last_pc       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run_en) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (run_en) begin
            cycle_count   <= cycle_next;
            instr_count   <= instr_next;
            rep_cnt       <= rep_next;
            pc_prev       <= pc_IF;
            pc_prev_valid <= 1'b1;
            if (halt_hit) begin
              state_q <= ST_HALT;
              last_pc <= pc_IF;
            end else if (to_hit) begin
              state_q <= ST_TIMEOUT;
              last_pc <= pc_IF;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign state   = state_q;
  assign done    = (state_q == ST_HALT) || (state_q == ST_TIMEOUT);
  assign halted  = (state_q == ST_HALT);
  assign timeout = (state_q == ST_TIMEOUT);

endmodule

// File: tb/tb_core_run_monitor.sv
// tb_core_run_monitor: scoreboard bench for core_run_monitor.
// Two instances share the same stimulus:
//   - dut0: default parameters (MAX_CYCLES=100, HALT_REPEAT=4).
//   - dut1: MAX_CYCLES=7, HALT_REPEAT=1.
// A reference model predicts each instance's outputs after every clock edge.
// The model is written in terms of active-cycle numbers and runs of equal PCs.
module tb_core_run_monitor;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int SAT = (1 << CW) - 1;
  localparam logic [31:0] HALT_I = 32'h1000FFFF;
  localparam logic [31:0] NOP_I  = 32'h00000000;
  localparam logic [31:0] ADDI_I = 32'h20080001;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run_en = 1'b0;
  logic [DW-1:0] pc_IF = '0;
  logic [DW-1:0] instr_ID = '0;
  logic [DW-1:0] instr_EX = '0;

  logic [1:0]    st0, st1;
  logic [CW-1:0] cc0, cc1, ic0, ic1;
  logic          dn0, dn1, hl0, hl1, to0, to1;
  logic [DW-1:0] lp0, lp1;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int          st;
    int          cyc;
    int          ins;
    logic [31:0] lpc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model state, one slot per instance
  int          max_c[2] = '{100, 7};
  int          hrep[2]  = '{4, 1};
  int          m_st[2];
  int          m_cyc[2];
  int          m_ins[2];
  int          m_run[2];
  logic [31:0] m_spc[2];
  logic [31:0] m_lpc[2];

  core_run_monitor #(.MAX_CYCLES(100), .HALT_REPEAT(4)) dut0 (
    .clk(clk), .rst(rst), .run_en(run_en), .pc_IF(pc_IF),
    .instr_ID(instr_ID), .instr_EX(instr_EX),
    .state(st0), .cycle_count(cc0), .instr_count(ic0),
    .done(dn0), .halted(hl0), .timeout(to0), .last_pc(lp0)
  );

  core_run_monitor #(.MAX_CYCLES(7), .HALT_REPEAT(1)) dut1 (
    .clk(clk), .rst(rst), .run_en(run_en), .pc_IF(pc_IF),
    .instr_ID(instr_ID), .instr_EX(instr_EX),
    .state(st1), .cycle_count(cc1), .instr_count(ic1),
    .done(dn1), .halted(hl1), .timeout(to1), .last_pc(lp1)
  );

  always #5 clk = ~clk;

  // Predict the effect of one clock edge with the given inputs.
  // The model tracks how many consecutive active samples share the current PC.
  function automatic void model_step(int k, bit r, bit en, logic [31:0] pc, logic [31:0] ins);
    bit halt;
    if (r) begin
      m_st[k] = 0; m_cyc[k] = 0; m_ins[k] = 0; m_run[k] = 0;
      m_spc[k] = '0; m_lpc[k] = '0;
      return;
    end
    if (m_st[k] == 0) begin
      if (en) m_st[k] = 1;
    end else if (m_st[k] == 1 && en) begin
      m_cyc[k] = (m_cyc[k] < SAT) ? m_cyc[k] + 1 : SAT;
      if (ins != NOP_I) m_ins[k] = (m_ins[k] < SAT) ? m_ins[k] + 1 : SAT;
      if (m_run[k] > 0 && pc == m_spc[k]) m_run[k]++;
      else m_run[k] = 1;
      m_spc[k] = pc;
      halt = (ins == HALT_I) || ((m_run[k] - 1) >= hrep[k]);
      if (halt) begin
        m_st[k] = 2; m_lpc[k] = pc;
      end else if (m_cyc[k] == max_c[k]) begin
        m_st[k] = 3; m_lpc[k] = pc;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkDut(input string tag, input exp_t e, input logic [1:0] st,
                          input logic [CW-1:0] cc, input logic [CW-1:0] ic,
                          input logic dn, input logic hl, input logic to,
                          input logic [31:0] lp);
    checkOutput({tag, ".state"}, 32'(st), 32'(e.st));
    checkOutput({tag, ".cycle_count"}, 32'(cc), 32'(e.cyc));
    checkOutput({tag, ".instr_count"}, 32'(ic), 32'(e.ins));
    checkOutput({tag, ".done"}, 32'(dn), 32'(e.st >= 2));
    checkOutput({tag, ".halted"}, 32'(hl), 32'(e.st == 2));
    checkOutput({tag, ".timeout"}, 32'(to), 32'(e.st == 3));
    checkOutput({tag, ".last_pc"}, lp, e.lpc);
  endtask

  // Drive one cycle of inputs and queue the predicted post-edge outputs
  task automatic applyStimulus(input bit r, input bit en, input logic [31:0] pc, input logic [31:0] ins);
    exp_t e;
    @(negedge clk);
    rst = r;
    run_en = en;
    pc_IF = pc;
    instr_EX = ins;
    instr_ID = $urandom;
    for (int k = 0; k < 2; k++) begin
      model_step(k, r, en, pc, ins);
      e.st = m_st[k]; e.cyc = m_cyc[k]; e.ins = m_ins[k]; e.lpc = m_lpc[k];
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic resetDut(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0, '0, '0);
  endtask

  // Raise reset between edges and confirm the outputs clear without a clock
  task automatic midReset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async.state0", 32'(st0), 0);
    checkOutput("async.cycle0", 32'(cc0), 0);
    checkOutput("async.instr0", 32'(ic0), 0);
    checkOutput("async.done0", 32'(dn0), 0);
    checkOutput("async.state1", 32'(st1), 0);
    checkOutput("async.cycle1", 32'(cc1), 0);
    applyStimulus(1'b1, 1'b0, '0, '0);
  endtask

  // Monitor: compare DUT outputs with the oldest prediction after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        checkDut("dut0", e, st0, cc0, ic0, dn0, hl0, to0, lp0);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        checkDut("dut1", e, st1, cc1, ic1, dn1, hl1, to1, lp1);
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized episodes
  initial begin
    logic [31:0] pc;
    logic [31:0] ins;
    bit          en;
    int          len;
    int          r;

    for (int k = 0; k < 2; k++) model_step(k, 1'b1, 1'b0, '0, '0);

    $display("[TB] reset and idle");
    resetDut(2);
    repeat (10) applyStimulus(1'b0, 1'b0, '0, '0);

    $display("[TB] timeout run");
    applyStimulus(1'b0, 1'b1, '0, ADDI_I);
    pc = '0;
    for (int i = 0; i < 120; i++) begin
      applyStimulus(1'b0, 1'b1, pc, ADDI_I);
      pc += 4;
    end
    repeat (3) applyStimulus(1'b0, 1'b0, pc, ADDI_I);

    $display("[TB] halt by stuck PC");
    resetDut(2);
    applyStimulus(1'b0, 1'b1, '0, NOP_I);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 32'(i * 4), NOP_I);
    repeat (8) applyStimulus(1'b0, 1'b1, 32'h10, NOP_I);

    $display("[TB] halt by halt instruction");
    resetDut(1);
    applyStimulus(1'b0, 1'b1, '0, ADDI_I);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b0, 1'b1, 32'(i * 4), (i == 7) ? HALT_I : ADDI_I);
    end

    $display("[TB] pause mid-run");
    resetDut(1);
    applyStimulus(1'b0, 1'b1, '0, ADDI_I);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 32'(i * 4), ADDI_I);
    repeat (2) applyStimulus(1'b0, 1'b1, 32'h100, NOP_I);
    repeat (5) applyStimulus(1'b0, 1'b0, 32'h100, ADDI_I);
    repeat (2) applyStimulus(1'b0, 1'b1, 32'h100, NOP_I);
    for (int i = 1; i <= 10; i++) applyStimulus(1'b0, 1'b1, 32'h100 + 32'(i * 4), ADDI_I);

    $display("[TB] reset mid-run then rerun");
    resetDut(1);
    applyStimulus(1'b0, 1'b1, '0, ADDI_I);
    for (int i = 0; i < 50; i++) applyStimulus(1'b0, 1'b1, 32'(i * 4), ADDI_I);
    midReset();
    applyStimulus(1'b0, 1'b1, '0, ADDI_I);
    for (int i = 0; i < 110; i++) applyStimulus(1'b0, 1'b1, 32'h400 + 32'(i * 4), ADDI_I);

    $display("[TB] randomized episodes");
    for (int ep = 0; ep < 10; ep++) begin
      resetDut(1);
      pc = $urandom & 32'hFFFF_FFFC;
      len = $urandom_range(40, 160);
      for (int i = 0; i < len; i++) begin
        en = ($urandom_range(0, 9) < 8);
        r = $urandom_range(0, 9);
        if (r == 9) pc = $urandom & 32'hFFFF_FFFC;
        else if (r >= 3) pc += 4;
        r = $urandom_range(0, 99);
        if (r < 15) ins = NOP_I;
        else if (r < 17) ins = HALT_I;
        else ins = $urandom;
        applyStimulus(1'b0, en, pc, ins);
      end
    end

    for (int i = 0; i < 10 && (q0.size() > 0 || q1.size() > 0); i++) @(posedge clk);
    #2;
    checkOutput("drain.q0", 32'(q0.size()), 0);
    checkOutput("drain.q1", 32'(q1.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
